// File: rtl/ntt_pkg.sv
// Shared types and helpers for the NTT butterfly scheduler and its write-back alignment.
package ntt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bf_state_t;

  localparam logic MODE_NTT  = 1'b0;
  localparam logic MODE_INTT = 1'b1;

  localparam int DEFAULT_LOG_N = 8;

  function automatic int calc_wb_lat(input int rd_lat, input int bf_lat);
    return rd_lat + bf_lat;
  endfunction

endpackage

// File: rtl/ntt_bf_sched_delay_line.sv
// Resettable shift register; delays a bus by DEPTH cycles to match a datapath latency.
module delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sr [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/ntt_bf_sched.sv
// In-place Gentleman-Sande NTT/INTT butterfly scheduler: read/twiddle address issue,
// stage drain, and latency-matched write-back addressing.
module ntt_bf_sched
  import ntt_pkg::*;
#(
  parameter int LOG_N  = DEFAULT_LOG_N,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG_N-1:0] rd_addr_a,
  output logic [LOG_N-1:0] rd_addr_b,
  output logic [LOG_N-1:0] tw_addr,
  output logic             bf_sel,
  output logic             wr_en,
  output logic [LOG_N-1:0] wr_addr_a,
  output logic [LOG_N-1:0] wr_addr_b
);

  localparam int H       = 1 << (LOG_N - 1);
  localparam int WB_LAT  = calc_wb_lat(RD_LAT, BF_LAT);
  localparam int CNT_MAX = (H > WB_LAT) ? H : WB_LAT;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int SW      = $clog2(LOG_N);
  localparam int DLW     = 1 + 2 * LOG_N;
  localparam logic [LOG_N-1:0] ONE = LOG_N'(1);

  bf_state_t       r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [SW-1:0]   r_s, w_s_nxt;
  logic            r_mode, w_mode_nxt;

  logic             r_busy, r_done, r_rd_en, r_bf_sel;
  logic [LOG_N-1:0] r_rd_a, r_rd_b, r_tw;

  logic [LOG_N-1:0] w_kx, w_h, w_t, w_j, w_a, w_b, w_tw;
  logic [LOG_N-2:0] w_tidx;
  logic [SW-1:0]    w_tsh;
  logic             w_issue_nxt;
  logic [DLW-1:0]   w_dl_q;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_s_nxt     = r_s;
    w_mode_nxt  = r_mode;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_mode_nxt  = mode;
          w_s_nxt     = SW'(LOG_N - 1);
          w_cnt_nxt   = '0;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (r_cnt == CW'(H - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = DRAIN;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (r_cnt == CW'(WB_LAT - 1)) begin
          w_cnt_nxt = '0;
          if (r_s == '0) begin
            w_state_nxt = DONE;
          end else begin
            w_s_nxt     = r_s - 1'b1;
            w_state_nxt = ISSUE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Addresses are formed from the next-cycle k/s so the outputs can be registered.
  always_comb begin
    w_issue_nxt = (w_state_nxt == ISSUE);
    w_kx   = LOG_N'(w_cnt_nxt);
    w_h    = ONE << w_s_nxt;
    w_t    = w_kx & (w_h - ONE);
    w_j    = w_kx >> w_s_nxt;
    w_a    = ((w_j << w_s_nxt) << 1) | w_t;
    w_b    = w_a + w_h;
    w_tsh  = SW'(LOG_N - 1) - w_s_nxt;
    w_tidx = w_t[LOG_N-2:0] << w_tsh;
    w_tw   = {w_mode_nxt, w_tidx};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_s      <= '0;
      r_mode   <= MODE_NTT;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rd_en  <= 1'b0;
      r_rd_a   <= '0;
      r_rd_b   <= '0;
      r_tw     <= '0;
      r_bf_sel <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_s      <= w_s_nxt;
      r_mode   <= w_mode_nxt;
      r_busy   <= (w_state_nxt == ISSUE) || (w_state_nxt == DRAIN);
      r_done   <= (w_state_nxt == DONE);
      r_rd_en  <= w_issue_nxt;
      r_rd_a   <= w_issue_nxt ? w_a  : '0;
      r_rd_b   <= w_issue_nxt ? w_b  : '0;
      r_tw     <= w_issue_nxt ? w_tw : '0;
      r_bf_sel <= (w_state_nxt != IDLE) ? w_mode_nxt : 1'b0;
    end
  end

  // Write-back tuple trails the read tuple by the full read + butterfly latency.
  delay_line #(
    .WIDTH (DLW),
    .DEPTH (WB_LAT)
  ) u_wb_dly (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     ({r_rd_en, r_rd_a, r_rd_b}),
    .o_q     (w_dl_q)
  );

  assign busy      = r_busy;
  assign done      = r_done;
  assign rd_en     = r_rd_en;
  assign rd_addr_a = r_rd_a;
  assign rd_addr_b = r_rd_b;
  assign tw_addr   = r_tw;
  assign bf_sel    = r_bf_sel;
  assign {wr_en, wr_addr_a, wr_addr_b} = w_dl_q;

endmodule

// File: tb/tb_ntt_bf_sched.sv
// Randomized self-checking bench for ntt_bf_sched against a cycle-timeline reference model.
module tb_ntt_bf_sched;

  localparam int LOG_N  = 3;
  localparam int RD_LAT = 1;
  localparam int BF_LAT = 8;
  localparam int N      = 1 << LOG_N;
  localparam int H      = N / 2;
  localparam int WB     = RD_LAT + BF_LAT;
  localparam int DONE_C = LOG_N * (H + WB) + 1;
  localparam int LEN    = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic             busy, done, rd_en, bf_sel, wr_en;
  logic [LOG_N-1:0] rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b;

  ntt_bf_sched #(.LOG_N(LOG_N), .RD_LAT(RD_LAT), .BF_LAT(BF_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr),
    .bf_sel    (bf_sel),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;
  int n_wr, n_done, n_ovl;
  int e_rd [LEN];
  int e_a  [LEN];
  int e_b  [LEN];
  int e_tw [LEN];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Timeline of expected reads, offset from the start cycle, built block-by-block per stage.
  task automatic build_model(input int m);
    int idx;
    for (int c = 0; c < LEN; c++) begin
      e_rd[c] = 0; e_a[c] = 0; e_b[c] = 0; e_tw[c] = 0;
    end
    idx = 1;
    for (int s = LOG_N - 1; s >= 0; s--) begin
      int h;
      h = 1 << s;
      for (int j = 0; j < N / (2 * h); j++) begin
        for (int t = 0; t < h; t++) begin
          e_rd[idx] = 1;
          e_a[idx]  = j * 2 * h + t;
          e_b[idx]  = e_a[idx] + h;
          e_tw[idx] = m * H + t * (H / h);
          idx++;
        end
      end
      idx += WB;
    end
  endtask

  task automatic check_cycle(input int c, input int m);
    int wc;
    int ewr;
    wc  = c - WB;
    ewr = (wc >= 0) ? e_rd[wc] : 0;
    chk($sformatf("busy@%0d", c), 32'(busy), 32'((c >= 1 && c < DONE_C) ? 1 : 0));
    chk($sformatf("done@%0d", c), 32'(done), 32'((c == DONE_C) ? 1 : 0));
    chk($sformatf("rd_en@%0d", c), 32'(rd_en), 32'(e_rd[c]));
    chk($sformatf("bf_sel@%0d", c), 32'(bf_sel), 32'((c >= 1 && c <= DONE_C) ? m : 0));
    chk($sformatf("wr_en@%0d", c), 32'(wr_en), 32'(ewr));
    if (e_rd[c] != 0) begin
      chk($sformatf("rd_a@%0d", c), 32'(rd_addr_a), 32'(e_a[c]));
      chk($sformatf("rd_b@%0d", c), 32'(rd_addr_b), 32'(e_b[c]));
      chk($sformatf("tw@%0d", c), 32'(tw_addr), 32'(e_tw[c]));
    end
    if (ewr != 0) begin
      chk($sformatf("wr_a@%0d", c), 32'(wr_addr_a), 32'(e_a[wc]));
      chk($sformatf("wr_b@%0d", c), 32'(wr_addr_b), 32'(e_b[wc]));
    end
    n_wr   += int'(wr_en);
    n_done += int'(done);
    n_ovl  += int'(wr_en & rd_en);
  endtask

  // Entered and left 1 time unit after a rising edge; cycle 0 carries the start pulse.
  task automatic run_xfer(input int m, input bit inj, input int last_c);
    build_model(m);
    n_wr = 0; n_done = 0; n_ovl = 0;
    for (int c = 0; c <= last_c; c++) begin
      start = (c == 0) || (inj && (c == 2 || c == DONE_C || $urandom_range(0, 7) == 0));
      mode  = (c == 0) ? m[0] : 1'($urandom_range(0, 1));
      @(negedge clk);
      check_cycle(c, m);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("n_writes", 32'(n_wr), 32'(H * LOG_N));
    chk("n_done", 32'(n_done), 32'd1);
    chk("rd_wr_overlap", 32'(n_ovl), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_rd_a"}, 32'(rd_addr_a), 32'd0);
    chk({tag, "_rd_b"}, 32'(rd_addr_b), 32'd0);
    chk({tag, "_tw"}, 32'(tw_addr), 32'd0);
    chk({tag, "_bf_sel"}, 32'(bf_sel), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_a"}, 32'(wr_addr_a), 32'd0);
    chk({tag, "_wr_b"}, 32'(wr_addr_b), 32'd0);
  endtask

  task automatic run_abort(input int m, input int abort_c);
    build_model(m);
    for (int c = 0; c <= abort_c; c++) begin
      start = (c == 0);
      mode  = (c == 0) ? m[0] : 1'($urandom_range(0, 1));
      @(negedge clk);
      check_cycle(c, m);
      @(posedge clk); #1;
    end
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_async");
    n_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_done += int'(done);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < WB + 2; i++) begin
      @(negedge clk);
      n_done += int'(done);
      chk("post_rst_wr_en", 32'(wr_en), 32'd0);
    end
    chk("abort_no_done", 32'(n_done), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    #1 check_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_xfer(0, 1'b0, DONE_C + 1);
    run_xfer(1, 1'b0, DONE_C + 1);
    run_xfer(1, 1'b1, DONE_C + 1);
    run_xfer(0, 1'b1, DONE_C + 1);
    run_abort(0, 20);
    run_xfer(0, 1'b0, DONE_C + 1);
    run_xfer(0, 1'b0, DONE_C);
    run_xfer(1, 1'b0, DONE_C);
    run_xfer(0, 1'b0, DONE_C + 1);
    for (int r = 0; r < 4; r++) begin
      run_xfer(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DONE_C + 1);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/ntt_bf_sched.md
Name: ntt_bf_sched

Overview:
- Schedules one in-place N-point NTT or INTT.
- Issues butterfly read addresses to the dual-port coefficient RAM, twiddle addresses to the twiddle ROM, and the mode select to the 256-bit butterfly.
- Writes the butterfly results back in place, with write addresses delayed to match the read and butterfly latency.
- Sits between the polynomial-level controller (start/done handshake) and the butterfly datapath.

Parameters:
- LOG_N, 8, log2 of transform size N. Minimum 2.
- RD_LAT, 1, cycles from rd_en/address to RAM/ROM data at the butterfly a_i/b_i/omg inputs.
- BF_LAT, 8, butterfly latency from a_i/b_i/omg/sel sampling to a_o/b_o valid.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request. Sampled only in IDLE.
- mode  in  1  0 = NTT, 1 = INTT. Captured with start.
- busy  out  1  high while a transform is in progress.
- done  out  1  one-cycle pulse when the last write-back has completed.
- rd_en  out  1  coefficient RAM and twiddle ROM read strobe.
- rd_addr_a  out  LOG_N  upper butterfly operand address.
- rd_addr_b  out  LOG_N  lower butterfly operand address.
- tw_addr  out  LOG_N  twiddle ROM address: {bank bit = mode_r, LOG_N-1 index bits}.
- bf_sel  out  1  butterfly sel. Equals the captured mode for the whole transform.
- wr_en  out  1  write-back strobe.
- wr_addr_a  out  LOG_N  a_o destination address.
- wr_addr_b  out  LOG_N  b_o destination address.

Behaviour:
- Reset: async, active-low. FSM goes to IDLE. All outputs 0, all counters 0, write-delay pipeline cleared. Reset mid-transform aborts it: no done pulse, wr_en deasserts immediately.
- Define WB_LAT = RD_LAT + BF_LAT, and H = N/2.
- FSM states and transitions:
  - IDLE: if start=1, capture mode into mode_r, set s = LOG_N-1, k = 0, go to ISSUE.
  - ISSUE: rd_en=1 for exactly H consecutive cycles, with k = 0..H-1. After k = H-1, go to DRAIN with drain counter 0.
  - DRAIN: rd_en=0 for exactly WB_LAT cycles. Then, if s = 0, go to DONE; otherwise decrement s, clear k, go to ISSUE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- busy is 1 in ISSUE and DRAIN.
- start while busy is ignored. start in the DONE cycle is also ignored.
- Address generation per issued butterfly, with span h = 2^s, j = k>>s, t = k & (h-1):
  - rd_addr_a = (j << (s+1)) | t
  - rd_addr_b = rd_addr_a + h
  - tw_addr = {mode_r, t << (LOG_N-1-s)}
  - All three are registered outputs, valid in the same cycle as rd_en.
  - Stage order is s = LOG_N-1 down to 0 for both modes (Gentleman-Sande butterfly). Only the twiddle bank differs between modes.
- Write-back:
  - The tuple {rd_en, rd_addr_a, rd_addr_b} is delayed by exactly WB_LAT cycles through a shift pipeline.
  - wr_en/wr_addr_a/wr_addr_b equal the read outputs from WB_LAT cycles earlier.
- Hazard rule:
  - The last write of stage s occurs in the last DRAIN cycle.
  - The first read of stage s-1 occurs one cycle later, so there is no read-after-write overlap. The RAM needs no bypass.
- bf_sel = mode_r from the start capture until IDLE. It is constant during the transform, so no delay matching is needed.
- Total latency, start cycle to done pulse: LOG_N*(H + WB_LAT) + 1 cycles.
- Widths: k and the drain counter are sized to hold max(H-1, WB_LAT-1). s is ceil(log2(LOG_N)) bits. No arithmetic overflow is possible.

Decomposition:
- Shared package ntt_pkg:
  - FSM state typedef {IDLE, ISSUE, DRAIN, DONE}.
  - Mode encodings NTT=0, INTT=1.
  - Default LOG_N.
  - Helper function computing WB_LAT.
- One sub-module, delay_line #(WIDTH, DEPTH): a resettable shift register carrying {valid, addr_a, addr_b} for write-back alignment. It is reusable wherever the butterfly latency must be matched.

Test Plan:
All scenarios use LOG_N=3, RD_LAT=1, BF_LAT=8, so WB_LAT=9.
1. NTT start, mode=0 -> rd_en runs 4 cycles per stage with a 9-cycle drain gap between stages:
   - Stage s=2: (a,b) = (0,4),(1,5),(2,6),(3,7), tw = 0,1,2,3.
   - Stage s=1: (0,2),(1,3),(4,6),(5,7), tw = 0,2,0,2.
   - Stage s=0: (0,1),(2,3),(4,5),(6,7), tw = 0,0,0,0.
   - done pulses 40 cycles after the start cycle.
2. INTT start, mode=1 -> same address pairs as scenario 1. tw = 4,5,6,7 / 4,6,4,6 / 4,4,4,4. bf_sel=1 throughout busy.
3. Write-back alignment -> every wr_en/wr_addr_a/wr_addr_b equals the rd_en/rd_addr_a/rd_addr_b from exactly 9 cycles earlier. Scoreboard across all 12 butterflies. No write occurs in the same cycle as the next stage's first read.
4. start pulsed mid-ISSUE and again in the DONE cycle -> ignored. Exactly one done pulse, mode_r unchanged, 12 writes total.
5. rst_n low during stage s=1 DRAIN -> all outputs 0 asynchronously. No done pulse. After release, a fresh start produces the full scenario-1 sequence.
6. Back-to-back: start in the cycle after done -> second transform is accepted, identical timing, captures its new mode.
